// File: rtl/led.sv
// Free-running 4-LED pattern sequencer: binary count, bouncing chase, all-blink.
// A prescaler paces one sequencer step every TICK_DIV clocks.
module led #(
  parameter int unsigned TICK_DIV = 32'd24_000_000
) (
  input  logic       CLOCK_48,
  input  logic       RESET_N,
  output logic [3:0] LED
);

  localparam int unsigned CNT_W = (TICK_DIV <= 32'd1) ? 1 : $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 32'd1);

  localparam logic [3:0] COUNT_LAST = 4'd15;
  localparam logic [3:0] CHASE_LAST = 4'd11;
  localparam logic [3:0] BLINK_LAST = 4'd3;

  typedef enum logic [1:0] {
    PH_COUNT = 2'd0,
    PH_CHASE = 2'd1,
    PH_BLINK = 2'd2
  } phase_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_c;
  phase_e           phase_q, phase_d;
  logic [3:0]       step_q, step_d;
  logic [3:0]       led_q, led_d;

  // Bounce pattern 1-2-4-8-4-2, played twice across steps 0..11.
  function automatic logic [3:0] chase_pattern(input logic [3:0] step);
    logic [3:0] pat;
    case (step)
      4'd0, 4'd6:                pat = 4'b0001;
      4'd1, 4'd5, 4'd7, 4'd11:   pat = 4'b0010;
      4'd2, 4'd4, 4'd8, 4'd10:   pat = 4'b0100;
      4'd3, 4'd9:                pat = 4'b1000;
      default:                   pat = 4'b0001;
    endcase
    return pat;
  endfunction

  // Prescaler: wraps at TICK_DIV-1 and flags the step tick on that count.
  always_comb begin
    tick_c = (cnt_q == TICK_LAST);
    cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
  end

  // State register.
  always_ff @(posedge CLOCK_48 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q   <= '0;
      phase_q <= PH_COUNT;
      step_q  <= 4'd0;
      led_q   <= 4'b0000;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      led_q   <= led_d;
    end
  end

  // Next phase/step, advancing only on a tick.
  always_comb begin
    phase_d = phase_q;
    step_d  = step_q;
    if (tick_c) begin
      case (phase_q)
        PH_COUNT: begin
          if (step_q == COUNT_LAST) begin
            phase_d = PH_CHASE;
            step_d  = 4'd0;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
        PH_CHASE: begin
          if (step_q == CHASE_LAST) begin
            phase_d = PH_BLINK;
            step_d  = 4'd0;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
        PH_BLINK: begin
          if (step_q == BLINK_LAST) begin
            phase_d = PH_COUNT;
            step_d  = 4'd0;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
        default: begin
          phase_d = PH_COUNT;
          step_d  = 4'd0;
        end
      endcase
    end
  end

  // LED pattern for the step being entered; held between ticks.
  always_comb begin
    led_d = led_q;
    if (tick_c) begin
      case (phase_d)
        PH_COUNT: led_d = step_d;
        PH_CHASE: led_d = chase_pattern(step_d);
        PH_BLINK: led_d = step_d[0] ? 4'b0000 : 4'b1111;
        default:  led_d = 4'b0000;
      endcase
    end
  end

  assign LED = led_q;

endmodule

// File: tb/tb_led.sv
// Randomised self-checking bench for the led sequencer, TICK_DIV=4 and TICK_DIV=1.
module tb_led;

  logic       clk;
  logic       rst4, rst1;
  logic [3:0] led4, led1;

  int checks   = 0;
  int failures = 0;
  int unsigned n4 = 0;
  int unsigned n1 = 0;

  led #(.TICK_DIV(4)) u_dut4 (.CLOCK_48(clk), .RESET_N(rst4), .LED(led4));
  led #(.TICK_DIV(1)) u_dut1 (.CLOCK_48(clk), .RESET_N(rst1), .LED(led1));

  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  // Expected LED after n rising edges since reset release, from the pattern rules.
  function automatic logic [3:0] model_led(input int unsigned n, input int unsigned td);
    int unsigned t, k, idx;
    t = (n / td) % 32;
    if (t < 16) return 4'(t);
    if (t < 28) begin
      k   = (t - 16) % 6;
      idx = (k < 4) ? k : 6 - k;
      return 4'(1 << idx);
    end
    return (((t - 28) % 2) == 0) ? 4'b1111 : 4'b0000;
  endfunction

  task automatic test_reset();
    rst4 = 1'b0;
    rst1 = 1'b0;
    #1;
    checks++;
    if (led4 !== 4'b0000) begin
      failures++;
      $display("FAIL reset_immediate_td4: got %b expected 0000", led4);
    end
    checks++;
    if (led1 !== 4'b0000) begin
      failures++;
      $display("FAIL reset_immediate_td1: got %b expected 0000", led1);
    end
    repeat (13) begin
      @(negedge clk);
      checks++;
      if (led4 !== 4'b0000) begin
        failures++;
        $display("FAIL reset_hold: got %b expected 0000 at %0t", led4, $time);
      end
    end
    rst4 = 1'b1;
    n4   = 0;
    repeat (8) begin
      @(posedge clk);
      n4++;
      @(negedge clk);
      checks++;
      if (led4 !== model_led(n4, 4)) begin
        failures++;
        $display("FAIL first_ticks edge %0d: got %b expected %b", n4, led4, model_led(n4, 4));
      end
      if (n4 == 3 || n4 == 4 || n4 == 8) begin
        checks++;
        if (led4 !== ((n4 == 3) ? 4'b0000 : (n4 == 4) ? 4'b0001 : 4'b0010)) begin
          failures++;
          $display("FAIL first_change edge %0d: got %b", n4, led4);
        end
      end
    end
  endtask

  task automatic test_full_cycle();
    // Runs past one full 128-clock period to check the wrap back to COUNT.
    repeat (140) begin
      @(posedge clk);
      n4++;
      @(negedge clk);
      checks++;
      if (led4 !== model_led(n4, 4)) begin
        failures++;
        $display("FAIL full_cycle edge %0d: got %b expected %b", n4, led4, model_led(n4, 4));
      end
      if (n4 == 64 || n4 == 112 || n4 == 128) begin
        checks++;
        if (led4 !== ((n4 == 64) ? 4'b0001 : (n4 == 112) ? 4'b1111 : 4'b0000)) begin
          failures++;
          $display("FAIL phase_boundary edge %0d: got %b", n4, led4);
        end
      end
    end
  endtask

  task automatic test_mid_chase_reset();
    int guard;
    guard = 0;
    while ((((n4 / 4) % 32) < 18) && guard < 200) begin
      @(posedge clk);
      n4++;
      guard++;
      @(negedge clk);
      checks++;
      if (led4 !== model_led(n4, 4)) begin
        failures++;
        $display("FAIL pre_chase edge %0d: got %b expected %b", n4, led4, model_led(n4, 4));
      end
    end
    checks++;
    if (guard >= 200) begin
      failures++;
      $display("FAIL chase_reach: got guard=%0d expected < 200", guard);
    end
    #2 rst4 = 1'b0;
    #1;
    checks++;
    if (led4 !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset_chase: got %b expected 0000", led4);
    end
    repeat (3) @(negedge clk);
    rst4 = 1'b1;
    n4   = 0;
    repeat (40) begin
      @(posedge clk);
      n4++;
      @(negedge clk);
      checks++;
      if (led4 !== model_led(n4, 4)) begin
        failures++;
        $display("FAIL restart edge %0d: got %b expected %b", n4, led4, model_led(n4, 4));
      end
    end
  endtask

  task automatic test_random_resets();
    int len, hold;
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(20, 150);
      repeat (len) begin
        @(posedge clk);
        n4++;
        @(negedge clk);
        checks++;
        if (led4 !== model_led(n4, 4)) begin
          failures++;
          $display("FAIL random run %0d edge %0d: got %b expected %b", it, n4, led4, model_led(n4, 4));
        end
      end
      #($urandom_range(1, 2)) rst4 = 1'b0;
      #1;
      hold = $urandom_range(1, 5);
      checks++;
      if (led4 !== 4'b0000) begin
        failures++;
        $display("FAIL random reset %0d: got %b expected 0000", it, led4);
      end
      repeat (hold) @(negedge clk);
      rst4 = 1'b1;
      n4   = 0;
    end
  endtask

  task automatic test_long_reset();
    rst4 = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      checks++;
      if (led4 !== 4'b0000) begin
        failures++;
        $display("FAIL long_reset: got %b expected 0000 at %0t", led4, $time);
      end
    end
    rst4 = 1'b1;
    n4   = 0;
    repeat (12) begin
      @(posedge clk);
      n4++;
      @(negedge clk);
      checks++;
      if (led4 !== model_led(n4, 4)) begin
        failures++;
        $display("FAIL after_long_reset edge %0d: got %b expected %b", n4, led4, model_led(n4, 4));
      end
    end
  endtask

  task automatic test_tick_div_one();
    @(negedge clk);
    checks++;
    if (led1 !== 4'b0000) begin
      failures++;
      $display("FAIL td1_reset: got %b expected 0000", led1);
    end
    rst1 = 1'b1;
    n1   = 0;
    repeat (70) begin
      @(posedge clk);
      n1++;
      @(negedge clk);
      checks++;
      if (led1 !== model_led(n1, 1)) begin
        failures++;
        $display("FAIL td1 edge %0d: got %b expected %b", n1, led1, model_led(n1, 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_mid_chase_reset();
    test_random_resets();
    test_long_reset();
    test_tick_div_one();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
